// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution/pooling engine.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEARN,
        FETCH,
        LATCH,
        RUN
    } state_t;

    // Width used to hand a dot product of any supported size to relu_sat.
    localparam int REF_W = 64;

    function automatic int dot_width(input int pix_w, input int taps);
        return 2 * pix_w + $clog2(taps) + 1;
    endfunction

    function automatic logic [31:0] relu_sat(input logic signed [REF_W-1:0] dot,
                                             input int pix_w);
        logic signed [REF_W-1:0] top;
        top = (64'sd1 <<< pix_w) - 64'sd1;
        if (dot[REF_W-1])
            return '0;
        if (dot > top)
            return 32'(top);
        return 32'(dot);
    endfunction

endpackage

// File: rtl/conv_dot.sv
// One kernel's dot product: unsigned pixels times signed weights, full precision.
module conv_dot
    import conv_pkg::*;
#(
    parameter int TAPS  = 4,
    parameter int PIX_W = 8,
    parameter int DOT_W = dot_width(PIX_W, TAPS)
) (
    input  logic [TAPS*PIX_W-1:0]    pixels,
    input  logic [TAPS*PIX_W-1:0]    weights,
    output logic signed [DOT_W-1:0]  dot
);

    logic signed [DOT_W-1:0] term [TAPS];

    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        logic signed [PIX_W:0]   px;
        logic signed [PIX_W-1:0] w;
        assign px      = signed'({1'b0, pixels[t*PIX_W +: PIX_W]});
        assign w       = signed'(weights[t*PIX_W +: PIX_W]);
        assign term[t] = DOT_W'(px) * DOT_W'(w);
    end

    always_comb begin
        dot = '0;
        for (int t = 0; t < TAPS; t++)
            dot = dot + term[t];
    end

endmodule

// File: rtl/conv_pool_engine.sv
// Kernel SRAM loader, weight fetch and streaming conv -> ReLU/saturate -> max-pool.
//   state | meaning
//   IDLE  | waiting for learn or classify
//   LEARN | each accepted beat writes one word per kernel at wr_ptr
//   FETCH | read cycle at cfg_addr
//   LATCH | capture SRAM read data into weights
//   RUN   | accept pixel windows, pool, emit results
module conv_pool_engine
    import conv_pkg::*;
#(
    parameter int NUM_KERNELS = 2,
    parameter int TAPS        = 4,
    parameter int PIX_W       = 8,
    parameter int ADDR_W      = 5,
    parameter int POOL_WIN    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                learn,
    input  logic                                classify,
    input  logic [ADDR_W-1:0]                   cfg_addr,
    input  logic [NUM_KERNELS*TAPS*PIX_W-1:0]   kr_wdata,
    input  logic                                pix_valid,
    output logic                                pix_ready,
    input  logic [TAPS*PIX_W-1:0]               pixels,
    output logic [ADDR_W-1:0]                   kmem_addr,
    output logic [NUM_KERNELS-1:0]              kmem_csb,
    output logic [NUM_KERNELS-1:0]              kmem_web,
    output logic [NUM_KERNELS-1:0]              kmem_oeb,
    output logic [NUM_KERNELS*TAPS*PIX_W-1:0]   kmem_wdata,
    input  logic [NUM_KERNELS*TAPS*PIX_W-1:0]   kmem_rdata,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [NUM_KERNELS*PIX_W-1:0]        result
);

    localparam int WORD_W = TAPS * PIX_W;
    localparam int DOT_W  = dot_width(PIX_W, TAPS);
    localparam int CNT_W  = (POOL_WIN > 1) ? $clog2(POOL_WIN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_WIN - 1);

    state_t                  state;
    logic [ADDR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]        pool_cnt;
    logic [PIX_W-1:0]        pool_max  [NUM_KERNELS];
    logic [WORD_W-1:0]       weights   [NUM_KERNELS];
    logic signed [DOT_W-1:0] dot       [NUM_KERNELS];
    logic [PIX_W-1:0]        relu      [NUM_KERNELS];
    logic [PIX_W-1:0]        pool_next [NUM_KERNELS];
    logic                    beat;
    logic                    pool_last;

    for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_kernel
        conv_dot #(
            .TAPS  (TAPS),
            .PIX_W (PIX_W),
            .DOT_W (DOT_W)
        ) u_dot (
            .pixels  (pixels),
            .weights (weights[k]),
            .dot     (dot[k])
        );
        assign relu[k]      = PIX_W'(relu_sat(REF_W'(dot[k]), PIX_W));
        assign pool_next[k] = (relu[k] > pool_max[k]) ? relu[k] : pool_max[k];
    end

    // Stall only when this beat would complete a pool while the previous result is still held.
    always_comb begin
        pix_ready = 1'b0;
        case (state)
            LEARN:   pix_ready = 1'b1;
            RUN:     pix_ready = !((pool_cnt == CNT_LAST) && res_valid && !res_ready);
            default: pix_ready = 1'b0;
        endcase
    end

    assign beat      = pix_valid & pix_ready;
    assign pool_last = (pool_cnt == CNT_LAST);

    always_comb begin
        kmem_csb   = '1;
        kmem_web   = '1;
        kmem_oeb   = '1;
        kmem_addr  = '0;
        kmem_wdata = '0;
        case (state)
            LEARN: begin
                kmem_addr = wr_ptr;
                if (beat) begin
                    kmem_csb   = '0;
                    kmem_web   = '0;
                    kmem_wdata = kr_wdata;
                end
            end
            FETCH: begin
                kmem_csb  = '0;
                kmem_oeb  = '0;
                kmem_addr = cfg_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            pool_cnt  <= '0;
            res_valid <= 1'b0;
            result    <= '0;
            for (int k = 0; k < NUM_KERNELS; k++) begin
                pool_max[k] <= '0;
                weights[k]  <= '0;
            end
        end else begin
            if (res_valid && res_ready)
                res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (learn) begin
                        state  <= LEARN;
                        wr_ptr <= '0;
                    end else if (classify) begin
                        state <= FETCH;
                    end
                end
                LEARN: begin
                    if (beat)
                        wr_ptr <= wr_ptr + 1'b1;
                    if (!learn)
                        state <= IDLE;
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    for (int k = 0; k < NUM_KERNELS; k++)
                        weights[k] <= kmem_rdata[k*WORD_W +: WORD_W];
                    state <= RUN;
                end
                RUN: begin
                    if (!classify) begin
                        state    <= IDLE;
                        pool_cnt <= '0;
                        for (int k = 0; k < NUM_KERNELS; k++)
                            pool_max[k] <= '0;
                    end else if (beat) begin
                        if (pool_last) begin
                            pool_cnt  <= '0;
                            res_valid <= 1'b1;
                            for (int k = 0; k < NUM_KERNELS; k++) begin
                                result[k*PIX_W +: PIX_W] <= pool_next[k];
                                pool_max[k]              <= '0;
                            end
                        end else begin
                            pool_cnt <= pool_cnt + 1'b1;
                            for (int k = 0; k < NUM_KERNELS; k++)
                                pool_max[k] <= pool_next[k];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Directed and randomized bench for conv_pool_engine with an SRAM model and pooling reference.
module tb_conv_pool_engine;

    localparam int NK   = 2;
    localparam int PWIN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        learn = 1'b0;
    logic        classify = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [63:0] kr_wdata = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [31:0] pixels = '0;
    logic [4:0]  kmem_addr;
    logic [1:0]  kmem_csb, kmem_web, kmem_oeb;
    logic [63:0] kmem_wdata;
    logic [63:0] kmem_rdata;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] result;

    int passed = 0;
    int total  = 0;

    logic [31:0] sram [NK][32];
    logic [63:0] rdata_q = '0;

    logic [31:0] exp_mem [NK][32];
    logic [31:0] cur_w [NK];
    logic [63:0] lw [$];
    logic [15:0] q [$];
    bit          m_valid = 1'b0;
    logic [15:0] m_result = '0;

    always #5 clk = ~clk;

    conv_pool_engine dut (
        .clk        (clk),
        .rst        (rst),
        .learn      (learn),
        .classify   (classify),
        .cfg_addr   (cfg_addr),
        .kr_wdata   (kr_wdata),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pixels     (pixels),
        .kmem_addr  (kmem_addr),
        .kmem_csb   (kmem_csb),
        .kmem_web   (kmem_web),
        .kmem_oeb   (kmem_oeb),
        .kmem_wdata (kmem_wdata),
        .kmem_rdata (kmem_rdata),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .result     (result)
    );

    // Single-port SRAM per kernel: read data appears the cycle after the read.
    always @(posedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (!kmem_csb[k]) begin
                if (!kmem_web[k])
                    sram[k][kmem_addr] <= kmem_wdata[k*32 +: 32];
                else if (!kmem_oeb[k])
                    rdata_q[k*32 +: 32] <= sram[k][kmem_addr];
            end
        end
    end
    assign kmem_rdata = rdata_q;

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int dot_ref(input logic [31:0] px, input logic [31:0] w);
        int s = 0;
        for (int t = 0; t < 4; t++) begin
            logic [7:0] pb;
            logic [7:0] wb;
            pb = px[t*8 +: 8];
            wb = w[t*8 +: 8];
            s += int'(pb) * int'($signed(wb));
        end
        return s;
    endfunction

    function automatic logic [7:0] relu_ref(input int s);
        if (s < 0)
            return 8'd0;
        if (s > 255)
            return 8'd255;
        return s[7:0];
    endfunction

    // One RUN cycle: predict pix_ready, decide acceptance, update the pooling model, check outputs.
    task automatic run_cycle(input bit v, input logic [31:0] px, input bit rr);
        bit          exp_rdy;
        logic [15:0] r;
        logic [7:0]  mx;
        pix_valid = v;
        pixels    = px;
        res_ready = rr;
        #1;
        exp_rdy = !(q.size() == PWIN - 1 && m_valid && !rr);
        chk("pix_ready", {127'd0, pix_ready}, {127'd0, exp_rdy});
        if (m_valid && rr)
            m_valid = 1'b0;
        if (v && exp_rdy) begin
            r = '0;
            for (int k = 0; k < NK; k++)
                r[k*8 +: 8] = relu_ref(dot_ref(px, cur_w[k]));
            q.push_back(r);
            if (q.size() == PWIN) begin
                for (int k = 0; k < NK; k++) begin
                    mx = 8'd0;
                    foreach (q[i])
                        if (q[i][k*8 +: 8] > mx)
                            mx = q[i][k*8 +: 8];
                    m_result[k*8 +: 8] = mx;
                end
                m_valid = 1'b1;
                q.delete();
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        chk("res_valid", {127'd0, res_valid}, {127'd0, m_valid});
        if (m_valid)
            chk("result", {112'd0, result}, {112'd0, m_result});
    endtask

    task automatic learn_session(input int n, input bit both, input bit drop_last);
        learn     = 1'b1;
        classify  = both;
        pix_valid = 1'b0;
        @(negedge clk);
        classify = 1'b0;
        #1 chk("learn_entry", {122'd0, pix_ready, kmem_csb, kmem_web}, {122'd0, 1'b1, 4'b1111});
        for (int i = 0; i < n; i++) begin
            kr_wdata  = lw[i];
            pix_valid = 1'b1;
            if (drop_last && i == n - 1)
                learn = 1'b0;
            #1;
            chk("learn_write", {53'd0, kmem_csb, kmem_web, kmem_oeb, kmem_addr, kmem_wdata},
                {53'd0, 4'b0000, 2'b11, 5'(i), lw[i]});
            exp_mem[0][i % 32] = lw[i][31:0];
            exp_mem[1][i % 32] = lw[i][63:32];
            @(negedge clk);
        end
        pix_valid = 1'b0;
        learn     = 1'b0;
        @(negedge clk);
        #1 chk("learn_exit", {125'd0, pix_ready, kmem_csb}, {125'd0, 1'b0, 2'b11});
    endtask

    task automatic do_fetch(input logic [4:0] a);
        classify  = 1'b1;
        cfg_addr  = a;
        res_ready = 1'b1;
        pix_valid = 1'b0;
        @(negedge clk);
        m_valid = 1'b0;
        #1 chk("fetch_read", {116'd0, kmem_csb, kmem_web, kmem_oeb, kmem_addr, pix_ready},
               {116'd0, 2'b00, 2'b11, 2'b00, a, 1'b0});
        @(negedge clk);
        #1 chk("latch_idle", {125'd0, kmem_csb, pix_ready}, {125'd0, 2'b11, 1'b0});
        for (int k = 0; k < NK; k++)
            cur_w[k] = exp_mem[k][a];
        @(negedge clk);
        q.delete();
    endtask

    task automatic drop_classify();
        classify  = 1'b0;
        pix_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        q.delete();
        #1 chk("drop_idle", {126'd0, pix_ready, res_valid}, {126'd0, 2'b00});
    endtask

    initial begin
        #2 rst = 1'b0;
        @(negedge clk);
        #1 chk("reset_outputs",
               {35'd0, kmem_csb, kmem_web, kmem_oeb, kmem_addr, kmem_wdata, pix_ready, res_valid, result},
               {35'd0, 6'b111111, 5'd0, 64'd0, 1'b0, 1'b0, 16'd0});
        rst = 1'b1;
        @(negedge clk);

        // 33 beats: learn and classify both high at entry, address wraps on the last beat.
        lw.delete();
        for (int i = 0; i < 33; i++)
            lw.push_back({32'($urandom), (i < 3) ? 32'h01020304 + 32'(i) * 32'h10101010 : 32'($urandom)});
        learn_session(33, 1'b1, 1'b0);

        // Reload table; the last word is written in the same cycle learn drops.
        lw.delete();
        lw.push_back({32'($urandom), 32'h01010101});
        lw.push_back({32'hFFFFFFFF, 32'h7F7F7F7F});
        for (int i = 2; i < 8; i++)
            lw.push_back({32'($urandom), 32'($urandom)});
        learn_session(8, 1'b0, 1'b1);

        do_fetch(5'd0);
        run_cycle(1'b1, 32'h01020304, 1'b1);
        run_cycle(1'b1, 32'h0A0A0A0A, 1'b1);
        run_cycle(1'b1, 32'h05050505, 1'b1);
        run_cycle(1'b1, 32'h02010101, 1'b1);
        chk("mac_pool_k0", {120'd0, result[7:0]}, {120'd0, 8'd40});

        for (int i = 0; i < 3; i++)
            run_cycle(1'b1, 32'($urandom), 1'b0);
        run_cycle(1'b1, 32'($urandom), 1'b0);
        chk("bp_result_held", {120'd0, result[7:0]}, {120'd0, 8'd40});
        run_cycle(1'b1, 32'($urandom), 1'b1);
        run_cycle(1'b0, 32'd0, 1'b1);

        run_cycle(1'b1, 32'($urandom), 1'b1);
        run_cycle(1'b1, 32'($urandom), 1'b1);
        drop_classify();

        do_fetch(5'd1);
        for (int i = 0; i < 4; i++)
            run_cycle(1'b1, 32'hFFFFFFFF, 1'b1);
        chk("sat_relu", {112'd0, result}, {112'd0, 16'h00FF});
        drop_classify();

        do_fetch(5'd7);
        for (int i = 0; i < 4; i++)
            run_cycle(1'b1, 32'($urandom), 1'b1);
        drop_classify();

        do_fetch(5'd5);
        for (int i = 0; i < 60; i++)
            run_cycle($urandom_range(0, 3) != 0, 32'($urandom), 1'($urandom_range(0, 1)));

        for (int i = 0; i < 4; i++)
            run_cycle(1'b1, 32'($urandom), 1'b0);
        #2 rst = 1'b0;
        classify = 1'b0;
        #1 chk("reset_mid_run",
               {35'd0, kmem_csb, kmem_web, kmem_oeb, kmem_addr, kmem_wdata, pix_ready, res_valid, result},
               {35'd0, 6'b111111, 5'd0, 64'd0, 1'b0, 1'b0, 16'd0});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 chk("post_reset_idle", {124'd0, pix_ready, res_valid, kmem_csb}, {124'd0, 2'b00, 2'b11});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/conv_pool_engine.md
Name: conv_pool_engine

Overview:
- Parametrised successor to the fixed two-kernel convolution top.
- Generalised in kernel count, taps, pixel width, memory depth and pool window.
- Adds a learn-mode kernel SRAM writer, a classify-mode weight fetch FSM, valid/ready pixel and result handshakes, and a streaming ReLU+saturate+max-pool datapath.
- Sits between the pixel source and the classifier layer; drives one single-port kernel SRAM per kernel.

Parameters:
- NUM_KERNELS, 2, number of kernels, SRAM ports and result lanes.
- TAPS, 4, pixels per window = weights per kernel word.
- PIX_W, 8, pixel, weight and result width.
- ADDR_W, 5, kernel SRAM address width; depth = 2**ADDR_W.
- POOL_WIN, 4, conv results per max-pool output; must be >= 1.
- Derived localparam: WORD_W = TAPS*PIX_W (32 at defaults).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- learn  in  1  level; requests kernel-load mode.
- classify  in  1  level; requests inference mode.
- cfg_addr  in  ADDR_W  kernel word address fetched on classify entry.
- kr_wdata  in  NUM_KERNELS x WORD_W  learn-mode write data, one word per kernel.
- pix_valid  in  1  input beat valid (pixels in classify, kr_wdata in learn).
- pix_ready  out  1  input beat accepted when pix_valid & pix_ready.
- pixels  in  TAPS x PIX_W  unsigned pixel window.
- kmem_addr  out  ADDR_W  shared SRAM address.
- kmem_csb, kmem_web, kmem_oeb  out  NUM_KERNELS each  active-low chip select / write enable / output enable.
- kmem_wdata  out  NUM_KERNELS x WORD_W  SRAM write data.
- kmem_rdata  in  NUM_KERNELS x WORD_W  SRAM read data; valid one cycle after the read cycle.
- res_valid  out  1  pooled result valid.
- res_ready  in  1  downstream accepts the result.
- result  out  NUM_KERNELS x PIX_W  pooled result per kernel.

Behaviour:
- Reset values: kmem_csb/web/oeb all 1, kmem_addr 0, kmem_wdata 0, pix_ready 0, res_valid 0, result 0. Internal: state IDLE, wr_ptr 0, pool_cnt 0, pool_max 0, weights 0.
- Reset mid-operation aborts immediately; any partial pool is lost.
- FSM states: IDLE, LEARN, FETCH, LATCH, RUN.
- IDLE -> LEARN if learn=1 (learn wins when both are high); wr_ptr cleared.
- IDLE -> FETCH if classify=1 and learn=0.
- LEARN:
  - pix_ready=1.
  - Each accepted beat drives csb=0, web=0, oeb=1, addr=wr_ptr, wdata=kr_wdata on all ports combinationally in that cycle, then increments wr_ptr.
  - wr_ptr wraps 2**ADDR_W-1 -> 0.
  - learn=0 -> IDLE next cycle; a beat in that same cycle is still written.
- FETCH (1 cycle): csb=0, web=1, oeb=0, addr=cfg_addr.
- LATCH (1 cycle): weights[k] <= kmem_rdata[k]; all controls inactive; -> RUN.
- RUN:
  - pix_ready = !(pool_cnt==POOL_WIN-1 && res_valid && !res_ready).
  - Per accepted beat, per kernel: dot = sum over taps of unsigned pixel x signed weight (byte t = bits t*PIX_W+:PIX_W), computed at full precision (2*PIX_W+clog2(TAPS)+1 bits signed).
  - relu_sat = 0 if dot<0, 2**PIX_W-1 if dot exceeds it, else dot.
  - If pool_cnt<POOL_WIN-1: pool_max <= max(pool_max, relu_sat), pool_cnt++.
  - Else: result <= max(pool_max, relu_sat), res_valid <= 1, pool_max <= 0, pool_cnt <= 0.
  - Latency: res_valid rises the cycle after the POOL_WIN-th accepted beat.
  - classify=0 -> IDLE; partial pool discarded (pool_cnt, pool_max cleared). A pending result stays valid until taken.
- res_valid clears on res_ready unless a new result loads in the same cycle; result holds while res_valid & !res_ready.
- In LEARN, FETCH and LATCH, pixels are ignored; in RUN, kr_wdata is ignored.

Decomposition:
- Package conv_pkg: state enum, relu_sat function, derived width constants.
- Sub-module conv_dot: one kernel's TAPS-wide signed dot product, combinational; instantiated NUM_KERNELS times via generate.

Test Plan:
- Learn: learn=1, 3 beats with kr_wdata k0 = 0x01020304, 0x11..., 0x21... -> csb=0/web=0 at addr 0,1,2; 33 beats -> addr wraps to 0 on beat 33.
- Fetch: classify=1, cfg_addr=5 -> one read cycle with addr=5, csb=0, oeb=0; RUN (pix_ready=1) on the 3rd cycle after entry.
- MAC/pool: weights 0x01010101, POOL_WIN=4, windows summing to 10, 40, 20, 5 -> result 40, res_valid one cycle after 4th beat.
- Saturation/ReLU: weights 0x7F7F7F7F with pixels 0xFF -> 255; weights 0xFFFFFFFF (-1) -> 0.
- Backpressure: res_ready=0 with result pending and pool_cnt=3 -> pix_ready=0; res_ready=1 -> next beat accepted, new result loads.
- Mode edges: learn and classify both 1 in IDLE -> LEARN. Drop classify after 2 beats -> IDLE, no result. Reset low mid-RUN -> all outputs at reset values.
